led_pattern_ctrl: RTL
=====================

# led_pattern_ctrl

Parametrised LED pattern generator that replaces the single-counter, two-colour LED driver in the board top level. A programmable-rate prescaler produces an advance tick. Each tick steps an NB_LEDS-wide pattern register through one of four modes: rotate left, rotate right, ping-pong, or flash. The pattern is routed to one of three colour buses, or to all three. Control comes from a 7-bit switch vector.

## Interface
- NB_LEDS, 4: pattern width; minimum 2.
- NB_COUNTER, 16: prescaler width.
- R0_LIMIT, (1<<NB_COUNTER)-1: terminal count for rate 0 (slowest).
- R1_LIMIT, R0_LIMIT>>1: terminal count for rate 1.
- R2_LIMIT, R0_LIMIT>>2: terminal count for rate 2.
- R3_LIMIT, R0_LIMIT>>3: terminal count for rate 3 (fastest).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_sw  in  7  [0] enable, [2:1] rate select, [4:3] mode, [6:5] colour.
- o_led  out  NB_LEDS  current pattern register.
- o_led_r  out  NB_LEDS  red bus.
- o_led_g  out  NB_LEDS  green bus.
- o_led_b  out  NB_LEDS  blue bus.
- o_tick  out  1  one-cycle pulse marking each pattern advance.

## Operation
- Rate select picks limit L from {R0..R3}_LIMIT; the decode is combinational from i_sw[2:1].
- Prescaler count is unsigned, NB_COUNTER bits.
  - enable=1 and count >= L: count <= 0 and the pattern advances.
  - enable=1 and count < L: count <= count+1.
  - Using >= means a switch to a faster rate mid-count advances on the next edge and never waits for a wrap.
- enable=0: count, pattern, direction and mode register all freeze; the colour buses keep tracking the frozen pattern.
- Modes, i_sw[4:3]:
  - 00 rotate left: one-hot, MSB wraps to bit 0. Init 0...01.
  - 01 rotate right: one-hot, bit 0 wraps to MSB. Init 0...01.
  - 10 ping-pong: one-hot with a direction flag, init bit 0 moving left. Leaving bit NB_LEDS-1 the direction flips to right; leaving bit 0 it flips to left. There are no repeated end states: 0001,0010,0100,1000,0100,0010,0001,0010...
  - 11 flash: all-ones / all-zeros toggle. Init all ones.
- Mode change: a registered copy mode_q is compared with i_sw[4:3]. When they differ, the next edge (regardless of enable) does the following:
  - pattern <= the new mode's init value
  - count <= 0
  - direction <= left
  - mode_q <= new mode
  - no advance and no o_tick

  Mode change takes priority over a simultaneous terminal count.
- Colour, i_sw[6:5]: 00 red, 01 green, 10 blue, 11 all three buses. Unselected buses are driven to 0.
- Colour buses are registered from (pattern, colour), so colour changes take effect without a reset.

## Timing
- Reset values:
  - count = 0
  - pattern = o_led = 0...01
  - direction = left
  - mode_q = 00
  - o_led_r = o_led_g = o_led_b = 0
  - o_tick = 0
- Advance period with enable held is L+1 cycles.
- o_tick goes high in the same cycle o_led shows the new pattern, for exactly one cycle.
- Colour buses lag o_led by 1 cycle; a colour-select change appears on the buses 1 cycle after it is sampled.
- Mode-change reload is visible on o_led 1 cycle after the new mode is sampled; the next advance follows L+1 cycles after the reload.
- Reset asserted mid-operation forces all reset values immediately. After deassertion the first advance occurs L+1 enabled cycles later.
- With enable rising, counting resumes from the frozen count; there is no restart.

## Test plan
Bench parameters: NB_COUNTER=4, NB_LEDS=4, so the limits are R0=15, R1=7, R2=3, R3=1.
- **Reset / basic rotate:** reset, then enable with rate 3, mode 00, colour 01. Required: o_led steps 0001→0010→0100→1000→0001 every 2 cycles; o_tick pulses on each step; o_led_g equals o_led delayed 1 cycle; o_led_r = o_led_b = 0.
- **Ping-pong and colour:** mode 10 at rate 3. Required: 0001,0010,0100,1000,0100,0010,0001,0010 with no repeated ends. With colour 11 all three buses are equal; switching colour to 10 gives o_led_b = pattern and the other buses 0, one cycle later.
- **Rate change mid-count:** rate 0, wait until count = 10, then select rate 2 (L=3). Required: advance and o_tick on the next edge, then every 4 cycles.
- **Mode change priority:** in mode 00 at the terminal count, switch to mode 11 in the same cycle. Required: o_led = 1111, no o_tick that cycle; then 0000, 1111, ... with the first toggle 2 cycles later at rate 3.
- **Freeze:** with enable=0 for 10 cycles mid-pattern, o_led and count hold and there is no o_tick. After re-enabling, the next advance arrives after the remaining count, not a full period.
- **Async reset:** assert i_reset between clock edges while the pattern is at 0100. Required: o_led = 0001 and all colour buses 0 before the next edge; o_tick = 0.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   LED pattern generator. A programmable-rate prescaler produces an advance
//   tick. Each tick steps an NB_LEDS-wide pattern through one of four modes:
//   rotate left, rotate right, ping-pong, or flash. The pattern is then routed
//   to one colour bus, or to all three.
//
// Ports
//   clock    : system clock; all state updates on the rising edge
//   i_reset  : asynchronous, active-high reset
//   i_sw     : [0] enable, [2:1] rate select, [4:3] mode, [6:5] colour
//   o_led    : current pattern register
//   o_led_r  : red bus   (pattern delayed 1 cycle, or 0 if not selected)
//   o_led_g  : green bus (pattern delayed 1 cycle, or 0 if not selected)
//   o_led_b  : blue bus  (pattern delayed 1 cycle, or 0 if not selected)
//   o_tick   : one-cycle pulse, high in the cycle o_led shows a new pattern
module led_pattern_ctrl #(
  parameter int          NB_LEDS    = 4,
  parameter int          NB_COUNTER = 16,
  parameter int unsigned R0_LIMIT   = (1 << NB_COUNTER) - 1,
  parameter int unsigned R1_LIMIT   = R0_LIMIT >> 1,
  parameter int unsigned R2_LIMIT   = R0_LIMIT >> 2,
  parameter int unsigned R3_LIMIT   = R0_LIMIT >> 3
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [6:0]         i_sw,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic               o_tick
);

  localparam logic [NB_COUNTER-1:0] LIM0 = NB_COUNTER'(R0_LIMIT);
  localparam logic [NB_COUNTER-1:0] LIM1 = NB_COUNTER'(R1_LIMIT);
  localparam logic [NB_COUNTER-1:0] LIM2 = NB_COUNTER'(R2_LIMIT);
  localparam logic [NB_COUNTER-1:0] LIM3 = NB_COUNTER'(R3_LIMIT);
  localparam logic [NB_LEDS-1:0]    ONE  = NB_LEDS'(1);

  localparam logic [1:0] M_ROTL  = 2'b00;
  localparam logic [1:0] M_ROTR  = 2'b01;
  localparam logic [1:0] M_PING  = 2'b10;
  localparam logic [1:0] M_FLASH = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // switch fields
  logic       sw_en;
  logic [1:0] sw_rate;
  logic [1:0] sw_mode;
  logic [1:0] sw_col;

  assign sw_en   = i_sw[0];
  assign sw_rate = i_sw[2:1];
  assign sw_mode = i_sw[4:3];
  assign sw_col  = i_sw[6:5];

  // state
  logic [NB_COUNTER-1:0] count_q,   count_d;
  logic [NB_LEDS-1:0]    pattern_q, pattern_d;
  logic                  dir_q,     dir_d;
  logic [1:0]            mode_q,    mode_d;
  logic                  tick_q,    tick_d;
  logic [NB_LEDS-1:0]    led_r_q,   led_r_d;
  logic [NB_LEDS-1:0]    led_g_q,   led_g_d;
  logic [NB_LEDS-1:0]    led_b_q,   led_b_d;

  logic [NB_COUNTER-1:0] limit;
  logic                  mode_chg;
  logic                  terminal;
  logic [NB_LEDS-1:0]    pattern_nxt;
  logic                  dir_nxt;

  // rate decode
  always_comb begin
    limit = LIM0;
    unique case (sw_rate)
      2'd0: limit = LIM0;
      2'd1: limit = LIM1;
      2'd2: limit = LIM2;
      2'd3: limit = LIM3;
      default: limit = LIM0;
    endcase
  end

  assign mode_chg = (mode_q != sw_mode);
  // >= so a switch to a faster rate mid-count fires on the next edge
  assign terminal = (count_q >= limit);

  // next pattern for one advance in the registered mode
  always_comb begin
    pattern_nxt = pattern_q;
    dir_nxt     = dir_q;
    unique case (mode_q)
      M_ROTL:  pattern_nxt = {pattern_q[NB_LEDS-2:0], pattern_q[NB_LEDS-1]};
      M_ROTR:  pattern_nxt = {pattern_q[0], pattern_q[NB_LEDS-1:1]};
      M_PING: begin
        // bounce off the ends without repeating the end state
        if (dir_q == DIR_LEFT) begin
          if (pattern_q[NB_LEDS-1]) begin
            pattern_nxt = pattern_q >> 1;
            dir_nxt     = DIR_RIGHT;
          end else begin
            pattern_nxt = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            pattern_nxt = pattern_q << 1;
            dir_nxt     = DIR_LEFT;
          end else begin
            pattern_nxt = pattern_q >> 1;
          end
        end
      end
      M_FLASH: pattern_nxt = ~pattern_q;
      default: pattern_nxt = pattern_q;
    endcase
  end

  // core next-state: mode change wins over enable and terminal count
  always_comb begin
    count_d   = count_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;
    if (mode_chg) begin
      pattern_d = (sw_mode == M_FLASH) ? '1 : ONE;
      count_d   = '0;
      dir_d     = DIR_LEFT;
      mode_d    = sw_mode;
    end else if (sw_en) begin
      if (terminal) begin
        count_d   = '0;
        pattern_d = pattern_nxt;
        dir_d     = dir_nxt;
        tick_d    = 1'b1;
      end else begin
        count_d = count_q + NB_COUNTER'(1);
      end
    end
  end

  // colour routing, registered from the current pattern
  always_comb begin
    led_r_d = ((sw_col == 2'b00) || (sw_col == 2'b11)) ? pattern_q : '0;
    led_g_d = ((sw_col == 2'b01) || (sw_col == 2'b11)) ? pattern_q : '0;
    led_b_d = ((sw_col == 2'b10) || (sw_col == 2'b11)) ? pattern_q : '0;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      count_q   <= '0;
      pattern_q <= ONE;
      dir_q     <= DIR_LEFT;
      mode_q    <= M_ROTL;
      tick_q    <= 1'b0;
      led_r_q   <= '0;
      led_g_q   <= '0;
      led_b_q   <= '0;
    end else begin
      count_q   <= count_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      led_r_q   <= led_r_d;
      led_g_q   <= led_g_d;
      led_b_q   <= led_b_d;
    end
  end

  assign o_led   = pattern_q;
  assign o_led_r = led_r_q;
  assign o_led_g = led_g_q;
  assign o_led_b = led_b_q;
  assign o_tick  = tick_q;

endmodule
